sprite_blitter: RTL and testbench
=================================

# sprite_blitter

Streams one stored image from a bank of on-chip image ROMs to the VGA frame-buffer writer as a sequence of (x, y, colour) pixel writes, placed at a requested origin on the screen. It sits between the UI/tuner control logic, which issues start requests, and the VGA adapter write port, which consumes pixels under a valid/ready handshake. It generalises image selection to a parametrised image count and geometry. It adds origin offset, screen clipping, optional transparency and backpressure.

## Interface
- NUM_IMAGES, 11, number of image ROMs; index 0 is the all-black image
- IMG_W, 160, image width in pixels
- IMG_H, 120, image height in pixels
- COLOR_W, 3, colour bits per pixel (RGB 1-1-1)
- SCR_W, 160, screen width; SCR_H, 120, screen height
- X_W, 8, screen x width; Y_W, 7, screen y width
- TRANSPARENT_EN, 0, when 1, pixels equal to TRANSPARENT_COLOR are not emitted
- TRANSPARENT_COLOR, 3'b000, colour treated as transparent
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse; accepted only when busy=0
- img_sel  in  $clog2(NUM_IMAGES)  image index, sampled with start
- x_org  in  X_W  screen x of image column 0; y_org  in  Y_W  screen y of image row 0
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse, same edge busy falls
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  consumer accepts pixel when valid&&ready
- pix_x  out  X_W; pix_y  out  Y_W; pix_color  out  COLOR_W

## Operation
- States: IDLE, RUN, DRAIN. All outputs reset to 0, state to IDLE, counters to 0.
- IDLE: on start=1, latch img_sel, x_org, y_org; col=row=0; go to RUN. If img_sel ≥ NUM_IMAGES, use index 0.
- RUN, stage 1: ROM address = row*IMG_W + col, on ADDR_W = $clog2(IMG_W*IMG_H) bits. It advances in raster order when stage 2 is empty or transferring. After the last address (IMG_W-1, IMG_H-1) issues, go to DRAIN.
- Stage 2 holds col/row of the address presented on the previous cycle, plus an occupied flag. ROM q is aligned with stage 2.
- Screen coordinates: sx = x_org + col and sy = y_org + row, computed one bit wider than X_W/Y_W.
- pix_valid = occupied && sx < SCR_W && sy < SCR_H && !(TRANSPARENT_EN && q == TRANSPARENT_COLOR). Clipped or transparent entries retire in one cycle without asserting valid.
- Stall: pix_valid && !pix_ready holds both stages and the ROM address. Because the address is held, q stays stable and pix_x/pix_y/pix_color stay stable.
- DRAIN: when stage 2 retires (transferred or suppressed), pulse done, drop busy, return to IDLE.
- start while busy=1 is ignored and has no queued effect.

## Timing
- start accepted at edge N: busy=1 after N. ROM address 0 is presented after N. First pix_valid can assert after edge N+1.
- Throughput: 1 pixel per cycle with pix_ready=1.
- With no clipping, transparency or stalls: done is high during the cycle after edge N+IMG_W*IMG_H+1, and busy falls at the same edge.
- Each stall cycle extends completion by exactly one cycle. Suppressed pixels cost one cycle each.
- ROM read latency: exactly 1 cycle (registered address, unregistered q).
- Image selection is held for the whole operation.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse is issued.

## Structure
- sprite_pkg: state enum (IDLE/RUN/DRAIN), pixel colour typedef, default geometry constants, black index constant (0).
- Sub-module image_rom_bank: instantiates the NUM_IMAGES ROMs on a shared address. It outputs the q selected by the latched index. An out-of-range index selects the black image; there are no holes in the selection.
- The top level holds the FSM, counters, stage-2 register and clip/transparency logic.

## Test plan
- img_sel=1, origin (0,0), pix_ready=1 -> exactly 19200 pixels in raster order, first at (0,0) two cycles after start, done at cycle 19201, colours match the ROM 1 image file.
- img_sel=3, origin (100,90) -> only pixels with sx<160 and sy<120 emitted (60×30=1800), no x/y wraparound, done still after 19201 cycles.
- Random pix_ready (50%) -> no pixel lost or duplicated, outputs stable while stalled, done delayed by exactly the number of stall cycles.
- TRANSPARENT_EN=1 with image 0 -> zero pix_valid cycles, done after 19201 cycles; img_sel=15 behaves identically to img_sel=0.
- start pulsed while busy -> ignored; reset asserted mid-RUN -> busy, pix_valid, done and all outputs 0 immediately; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/sprite_blitter_pkg.sv
// Shared definitions for the sprite blitter.
//   - state_t       : controller states (IDLE / RUN / DRAIN)
//   - color_t       : pixel colour at the default depth (RGB 1-1-1)
//   - DEF_*         : default image / screen geometry
//   - BLACK_INDEX   : image index that is all black; also the fallback image
//   - image_pixel() : content of the built-in image ROMs. Image k (k != 0)
//                     holds addr ^ (addr >> 5) ^ k, truncated to the colour width.
package sprite_blitter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_NUM_IMAGES = 11;
    localparam int DEF_IMG_W      = 160;
    localparam int DEF_IMG_H      = 120;
    localparam int DEF_COLOR_W    = 3;
    localparam int DEF_SCR_W      = 160;
    localparam int DEF_SCR_H      = 120;
    localparam int DEF_X_W        = 8;
    localparam int DEF_Y_W        = 7;

    localparam int BLACK_INDEX    = 0;

    typedef logic [DEF_COLOR_W-1:0] color_t;

    // Image content as a pure function of (image index, linear address).
    // Callers keep only the low colour bits.
    function automatic logic [31:0] image_pixel(input int idx, input logic [31:0] addr);
        return addr ^ (addr >> 5) ^ 32'(idx);
    endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Control and pixel-stream bundle of the sprite blitter.
//   start/img_sel/x_org/y_org : blit request from the control logic
//   busy/done                 : operation status (done is a one-cycle pulse)
//   pix_valid/pix_ready       : pixel handshake towards the frame-buffer writer
//   pix_x/pix_y/pix_color     : pixel write payload
// master = requester/consumer side, slave = the blitter.
interface sprite_blitter_if #(
    parameter int SEL_W   = 4,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
);
    logic               start;
    logic [SEL_W-1:0]   img_sel;
    logic [X_W-1:0]     x_org;
    logic [Y_W-1:0]     y_org;
    logic               busy;
    logic               done;
    logic               pix_valid;
    logic               pix_ready;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [COLOR_W-1:0] pix_color;

    modport master (
        output start, img_sel, x_org, y_org, pix_ready,
        input  busy, done, pix_valid, pix_x, pix_y, pix_color
    );

    modport slave (
        input  start, img_sel, x_org, y_org, pix_ready,
        output busy, done, pix_valid, pix_x, pix_y, pix_color
    );
endinterface

// File: rtl/sprite_blitter_image_rom_bank.sv
// Bank of NUM_IMAGES image ROMs sharing one address.
//   clk, reset : clock, asynchronous active-high reset
//   en         : address register load enable (low = hold, keeps q stable)
//   addr       : linear pixel address (row*IMG_W + col)
//   sel        : latched image index; any out-of-range value reads black
//   q          : colour at the registered address, one cycle after addr
module sprite_blitter_image_rom_bank
    import sprite_blitter_pkg::*;
#(
    parameter int NUM_IMAGES = DEF_NUM_IMAGES,
    parameter int ADDR_W     = 15,
    parameter int COLOR_W    = DEF_COLOR_W,
    parameter int SEL_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [SEL_W-1:0]   sel,
    output logic [COLOR_W-1:0] q
);

    logic [ADDR_W-1:0]  addr_reg;
    logic [COLOR_W-1:0] img_q [NUM_IMAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg <= '0;
        end else if (en) begin
            addr_reg <= addr;
        end
    end

    for (genvar gi = 0; gi < NUM_IMAGES; gi++) begin : g_img
        if (gi == BLACK_INDEX) begin : g_black
            assign img_q[gi] = '0;
        end else begin : g_pattern
            assign img_q[gi] = COLOR_W'(image_pixel(gi, 32'(addr_reg)));
        end
    end

    // Explicit compare per image so that every index outside the bank
    // falls through to black rather than aliasing a real image.
    always_comb begin
        q = '0;
        for (int i = 0; i < NUM_IMAGES; i++) begin
            if (sel == SEL_W'(i)) begin
                q = img_q[i];
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Streams one stored image as (x, y, colour) pixel writes placed at a
// requested screen origin, with clipping, optional transparency and
// valid/ready backpressure.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : sprite_blitter_if slave (start/img_sel/x_org/y_org in,
//                busy/done out, pix_valid/pix_ready handshake, pix_x/pix_y/pix_color out)
// Pipeline: stage 1 = raster col/row counters driving the ROM address;
// stage 2 = col/row of the previously presented address, aligned with ROM q.
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int NUM_IMAGES                   = DEF_NUM_IMAGES,
    parameter int IMG_W                        = DEF_IMG_W,
    parameter int IMG_H                        = DEF_IMG_H,
    parameter int COLOR_W                      = DEF_COLOR_W,
    parameter int SCR_W                        = DEF_SCR_W,
    parameter int SCR_H                        = DEF_SCR_H,
    parameter int X_W                          = DEF_X_W,
    parameter int Y_W                          = DEF_Y_W,
    parameter int TRANSPARENT_EN               = 0,
    parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = '0
) (
    input  logic clk,
    input  logic reset,
    sprite_blitter_if.slave bus
);

    localparam int SEL_W  = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;
    localparam int ADDR_W = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

    state_t state_reg, state_next;
    logic   done_reg, done_next;

    // Request latched at acceptance and held for the whole blit.
    logic [SEL_W-1:0]   sel_reg;
    logic [X_W-1:0]     x_org_reg;
    logic [Y_W-1:0]     y_org_reg;

    // Stage 1: next address to present.
    logic [COL_W-1:0]   col_reg;
    logic [ROW_W-1:0]   row_reg;

    // Stage 2: address presented last cycle, paired with ROM q.
    logic [COL_W-1:0]   s2_col_reg;
    logic [ROW_W-1:0]   s2_row_reg;
    logic               s2_occ_reg;

    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_q;
    logic [X_W:0]       sx;
    logic [Y_W:0]       sy;
    logic               on_screen;
    logic               transparent;
    logic               pix_valid;
    logic               retire;
    logic               advance;
    logic               last_addr;

    sprite_blitter_image_rom_bank #(
        .NUM_IMAGES (NUM_IMAGES),
        .ADDR_W     (ADDR_W),
        .COLOR_W    (COLOR_W),
        .SEL_W      (SEL_W)
    ) u_rom_bank (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .addr  (rom_addr),
        .sel   (sel_reg),
        .q     (rom_q)
    );

    assign rom_addr  = ADDR_W'(32'(row_reg) * IMG_W + 32'(col_reg));
    assign last_addr = (col_reg == LAST_COL) && (row_reg == LAST_ROW);

    // One bit wider than the screen coordinate so that off-screen positions
    // are clipped instead of wrapping back onto the screen.
    assign sx = (X_W+1)'(x_org_reg) + (X_W+1)'(s2_col_reg);
    assign sy = (Y_W+1)'(y_org_reg) + (Y_W+1)'(s2_row_reg);

    assign on_screen   = (sx < (X_W+1)'(SCR_W)) && (sy < (Y_W+1)'(SCR_H));
    assign transparent = (TRANSPARENT_EN != 0) && (rom_q == TRANSPARENT_COLOR);
    assign pix_valid   = s2_occ_reg && on_screen && !transparent;

    // Suppressed entries leave stage 2 without waiting for the consumer.
    assign retire  = s2_occ_reg && (!pix_valid || bus.pix_ready);
    assign advance = (state_reg == RUN) && (!s2_occ_reg || retire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (advance && last_addr) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (retire) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_reg    <= '0;
            x_org_reg  <= '0;
            y_org_reg  <= '0;
            col_reg    <= '0;
            row_reg    <= '0;
            s2_col_reg <= '0;
            s2_row_reg <= '0;
            s2_occ_reg <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && bus.start) begin
                sel_reg   <= bus.img_sel;
                x_org_reg <= bus.x_org;
                y_org_reg <= bus.y_org;
                col_reg   <= '0;
                row_reg   <= '0;
            end else if (advance && !last_addr) begin
                if (col_reg == LAST_COL) begin
                    col_reg <= '0;
                    row_reg <= row_reg + ROW_W'(1);
                end else begin
                    col_reg <= col_reg + COL_W'(1);
                end
            end

            if (advance) begin
                s2_col_reg <= col_reg;
                s2_row_reg <= row_reg;
                s2_occ_reg <= 1'b1;
            end else if (retire) begin
                s2_occ_reg <= 1'b0;
            end
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = done_reg;
    assign bus.pix_valid = pix_valid;
    // Payload is zero whenever no pixel is offered.
    assign bus.pix_x     = pix_valid ? sx[X_W-1:0] : '0;
    assign bus.pix_y     = pix_valid ? sy[Y_W-1:0] : '0;
    assign bus.pix_color = pix_valid ? rom_q : '0;

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;
    import sprite_blitter_pkg::*;

    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;
    localparam int NPIX  = IMG_W * IMG_H;

    typedef struct {
        int sel;
        int xo;
        int yo;
        bit rnd;
        int exp_count;
    } vec_t;

    typedef struct {
        int x;
        int y;
        int c;
    } px_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tab [3];

    always #5 clk = ~clk;

    sprite_blitter_if #(.SEL_W(4), .X_W(8), .Y_W(7), .COLOR_W(3)) bus_a ();
    sprite_blitter_if #(.SEL_W(4), .X_W(8), .Y_W(7), .COLOR_W(3)) bus_b ();

    sprite_blitter #(
        .NUM_IMAGES(11), .IMG_W(IMG_W), .IMG_H(IMG_H), .COLOR_W(3),
        .SCR_W(SCR_W), .SCR_H(SCR_H), .X_W(8), .Y_W(7),
        .TRANSPARENT_EN(0), .TRANSPARENT_COLOR(3'b000)
    ) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    sprite_blitter #(
        .NUM_IMAGES(11), .IMG_W(IMG_W), .IMG_H(IMG_H), .COLOR_W(3),
        .SCR_W(SCR_W), .SCR_H(SCR_H), .X_W(8), .Y_W(7),
        .TRANSPARENT_EN(1), .TRANSPARENT_COLOR(3'b000)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    // Image file contents: image 0 and any missing index are black,
    // image k holds (a ^ (a >> 5) ^ k) mod 8 at linear address a = r*W + c.
    function automatic int ref_color(input int sel, input int c, input int r);
        int a;
        if (sel <= 0 || sel >= 11) return 0;
        a = r * IMG_W + c;
        return (a ^ (a >> 5) ^ sel) & 7;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_main(input vec_t v, input int idx);
        px_t exp_q[$];
        px_t p;
        int  k, stalls, xfers, first_k, done_k, budget, hold_val, cur_val;
        bit  held;
        // Expected stream: every on-screen pixel in raster order.
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (v.xo + c < SCR_W && v.yo + r < SCR_H) begin
                    p.x = v.xo + c;
                    p.y = v.yo + r;
                    p.c = ref_color(v.sel, c, r);
                    exp_q.push_back(p);
                end
            end
        end
        @(negedge clk);
        bus_a.img_sel   = 4'(v.sel);
        bus_a.x_org     = 8'(v.xo);
        bus_a.y_org     = 7'(v.yo);
        bus_a.start     = 1'b1;
        bus_a.pix_ready = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        check($sformatf("busy_after_start[%0d]", idx), int'(bus_a.busy), 1);
        k = 0; stalls = 0; xfers = 0; first_k = -1; done_k = -1;
        held = 1'b0; hold_val = 0;
        budget = NPIX + 100 + (v.rnd ? 6 * v.exp_count : 0);
        while (k <= budget) begin
            // A second request mid-blit with different parameters must be ignored.
            if (k == 1000) begin
                bus_a.start   = 1'b1;
                bus_a.img_sel = 4'd7;
                bus_a.x_org   = 8'd3;
                bus_a.y_org   = 7'd2;
            end else begin
                bus_a.start = 1'b0;
            end
            bus_a.pix_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cur_val = int'({bus_a.pix_valid, bus_a.pix_x, bus_a.pix_y, bus_a.pix_color});
            if (held) begin
                check("stall_hold", cur_val, hold_val);
                held = 1'b0;
            end
            if (bus_a.done) begin
                done_k = k;
                break;
            end
            if (bus_a.pix_valid) begin
                if (first_k < 0) first_k = k;
                if (bus_a.pix_ready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL pixel_extra: got (%0d,%0d,%0d), expected no pixel",
                                 bus_a.pix_x, bus_a.pix_y, bus_a.pix_color);
                    end else begin
                        p = exp_q.pop_front();
                        if (int'(bus_a.pix_x) != p.x || int'(bus_a.pix_y) != p.y ||
                            int'(bus_a.pix_color) != p.c) begin
                            n_bad++;
                            $display("FAIL pixel[%0d]: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)",
                                     xfers, bus_a.pix_x, bus_a.pix_y, bus_a.pix_color,
                                     p.x, p.y, p.c);
                        end
                    end
                    xfers++;
                end else begin
                    stalls++;
                    held     = 1'b1;
                    hold_val = cur_val;
                end
            end
            @(negedge clk);
            k++;
        end
        check($sformatf("done_cycle[%0d]", idx), done_k, NPIX + 1 + stalls);
        check($sformatf("first_valid[%0d]", idx), first_k, 1);
        check($sformatf("pixel_count[%0d]", idx), xfers, v.exp_count);
        check($sformatf("busy_at_done[%0d]", idx), int'(bus_a.busy), 0);
        $display("run %0d: img=%0d org=(%0d,%0d) pixels=%0d stalls=%0d done at +%0d",
                 idx, v.sel, v.xo, v.yo, xfers, stalls, done_k);
        @(negedge clk);
        check($sformatf("done_pulse_width[%0d]", idx), int'(bus_a.done), 0);
        repeat (3) begin
            check($sformatf("no_queued_start[%0d]", idx), int'(bus_a.busy), 0);
            @(negedge clk);
        end
    endtask

    task automatic run_trans(input int sel);
        int k, nvalid, done_k, exp_n;
        exp_n = 0;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                if (c < SCR_W && r < SCR_H && ref_color(sel, c, r) != 0) exp_n++;
        @(negedge clk);
        bus_b.img_sel   = 4'(sel);
        bus_b.x_org     = 8'd0;
        bus_b.y_org     = 7'd0;
        bus_b.start     = 1'b1;
        bus_b.pix_ready = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        k = 0; nvalid = 0; done_k = -1;
        while (k <= NPIX + 100) begin
            if (bus_b.pix_valid) nvalid++;
            if (bus_b.done) begin
                done_k = k;
                break;
            end
            @(negedge clk);
            k++;
        end
        check($sformatf("trans_done_cycle[sel=%0d]", sel), done_k, NPIX + 1);
        check($sformatf("trans_valid_cycles[sel=%0d]", sel), nvalid, exp_n);
        $display("transparent run: img=%0d valid cycles=%0d done at +%0d", sel, nvalid, done_k);
        @(negedge clk);
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        bus_a.img_sel   = 4'd2;
        bus_a.x_org     = 8'd10;
        bus_a.y_org     = 7'd5;
        bus_a.start     = 1'b1;
        bus_a.pix_ready = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (50) @(negedge clk);
        check("pre_reset_busy", int'(bus_a.busy), 1);
        check("pre_reset_valid", int'(bus_a.pix_valid), 1);
        rst_a = 1'b1;
        #1;
        check("mid_reset_busy", int'(bus_a.busy), 0);
        check("mid_reset_done", int'(bus_a.done), 0);
        check("mid_reset_valid", int'(bus_a.pix_valid), 0);
        check("mid_reset_payload",
              int'({bus_a.pix_x, bus_a.pix_y, bus_a.pix_color}), 0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_no_done", int'({bus_a.done, bus_a.busy}), 0);
        end
        $display("reset mid-run: outputs cleared, no done pulse");
    endtask

    initial begin
        tab[0] = '{sel: 1, xo: 0,   yo: 0,  rnd: 1'b0, exp_count: 19200};
        tab[1] = '{sel: 3, xo: 100, yo: 90, rnd: 1'b0, exp_count: 1800};
        tab[2] = '{sel: 5, xo: 100, yo: 90, rnd: 1'b1, exp_count: 1800};

        bus_a.start = 1'b0; bus_a.img_sel = '0; bus_a.x_org = '0; bus_a.y_org = '0;
        bus_a.pix_ready = 1'b1;
        bus_b.start = 1'b0; bus_b.img_sel = '0; bus_b.x_org = '0; bus_b.y_org = '0;
        bus_b.pix_ready = 1'b1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus_a.busy), 0);
        check("reset_done", int'(bus_a.done), 0);
        check("reset_valid", int'(bus_a.pix_valid), 0);
        check("reset_payload", int'({bus_a.pix_x, bus_a.pix_y, bus_a.pix_color}), 0);
        check("reset_b_status", int'({bus_b.busy, bus_b.done, bus_b.pix_valid}), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        fork
            begin
                reset_mid_run();
                for (int i = 0; i < 3; i++) run_main(tab[i], i);
            end
            begin
                run_trans(0);
                run_trans(15);
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
